// File: rtl/multicycle_control.sv
// Multi-cycle control unit: accepts one opcode per handshake and sequences
// execute, memory and write-back phases, with a sticky memory-timeout fault.
module multicycle_control #(
  parameter int OPW     = 4,
  parameter int ALUW    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  input  logic [OPW-1:0]  opcode,
  output logic            instr_ready,
  input  logic            mem_ack,
  output logic            WE,
  output logic            demux_sel,
  output logic            W,
  output logic            R,
  output logic [ALUW-1:0] alucode,
  output logic            busy,
  output logic            illegal,
  output logic            fault
);

  localparam int CNTW = $clog2(TIMEOUT + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);

  localparam logic [OPW-1:0] OP_NOP = OPW'(0);
  localparam logic [OPW-1:0] OP_A1  = OPW'(1);
  localparam logic [OPW-1:0] OP_A2  = OPW'(2);
  localparam logic [OPW-1:0] OP_A3  = OPW'(3);
  localparam logic [OPW-1:0] OP_A4  = OPW'(4);
  localparam logic [OPW-1:0] OP_A5  = OPW'(5);
  localparam logic [OPW-1:0] OP_A6  = OPW'(6);
  localparam logic [OPW-1:0] OP_SW  = OPW'(7);
  localparam logic [OPW-1:0] OP_LW  = OPW'(8);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_FAULT
  } state_t;

  typedef struct packed {
    logic            instr_ready;
    logic            we;
    logic            demux_sel;
    logic            w;
    logic            r;
    logic            busy;
    logic            fault;
    logic [ALUW-1:0] alucode;
  } ctrl_t;

  state_t          state, state_nxt;
  logic [OPW-1:0]  op_q, op_nxt;
  logic [CNTW-1:0] cnt, cnt_nxt;
  logic            illegal_nxt;
  ctrl_t           ctrl_q;

  function automatic logic [ALUW-1:0] alu_of(input logic [OPW-1:0] op);
    logic [ALUW-1:0] a;
    a = '0;
    case (op)
      OP_A1:   a = ALUW'(4'b0000);
      OP_A2:   a = ALUW'(4'b0001);
      OP_A3:   a = ALUW'(4'b0010);
      OP_A4:   a = ALUW'(4'b0110);
      OP_A5:   a = ALUW'(4'b0111);
      OP_A6:   a = ALUW'(4'b1100);
      default: a = '0;
    endcase
    return a;
  endfunction

  // Output decode of a (state, opcode) pair; registered from the next-state
  // values so every output is a flop yet still Moore-aligned with the state.
  function automatic ctrl_t decode(input state_t s, input logic [OPW-1:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_IDLE: c.instr_ready = 1'b1;
      S_EXEC: begin
        c.we      = 1'b1;
        c.busy    = 1'b1;
        c.alucode = alu_of(op);
      end
      S_MEM: begin
        c.busy = 1'b1;
        if (op == OP_SW) begin
          c.w         = 1'b1;
          c.demux_sel = 1'b1;
        end else begin
          c.r = 1'b1;
        end
      end
      S_WB: begin
        c.we        = 1'b1;
        c.demux_sel = 1'b1;
        c.busy      = 1'b1;
      end
      S_FAULT: c.fault = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_nxt   = state;
    op_nxt      = op_q;
    cnt_nxt     = cnt;
    illegal_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (instr_valid) begin
          op_nxt = opcode;
          case (opcode)
            OP_NOP: state_nxt = S_IDLE;
            OP_A1, OP_A2, OP_A3, OP_A4, OP_A5, OP_A6: state_nxt = S_EXEC;
            OP_SW, OP_LW: begin
              state_nxt = S_MEM;
              cnt_nxt   = '0;
            end
            default: illegal_nxt = 1'b1;
          endcase
        end
      end
      S_EXEC: state_nxt = S_IDLE;
      // An ack on the same edge as the timeout limit completes normally.
      S_MEM: begin
        if (mem_ack) begin
          state_nxt = (op_q == OP_LW) ? S_WB : S_IDLE;
        end else begin
          cnt_nxt = cnt + CNTW'(1);
          if (cnt == CNT_LAST) begin
            state_nxt = S_FAULT;
          end
        end
      end
      S_WB:    state_nxt = S_IDLE;
      S_FAULT: state_nxt = S_FAULT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      op_q    <= '0;
      cnt     <= '0;
      illegal <= 1'b0;
      ctrl_q  <= decode(S_IDLE, '0);
    end else begin
      state   <= state_nxt;
      op_q    <= op_nxt;
      cnt     <= cnt_nxt;
      illegal <= illegal_nxt;
      ctrl_q  <= decode(state_nxt, op_nxt);
    end
  end

  assign instr_ready = ctrl_q.instr_ready;
  assign WE          = ctrl_q.we;
  assign demux_sel   = ctrl_q.demux_sel;
  assign W           = ctrl_q.w;
  assign R           = ctrl_q.r;
  assign busy        = ctrl_q.busy;
  assign fault       = ctrl_q.fault;
  assign alucode     = ctrl_q.alucode;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Sequential, parametrised control unit for the datapath: the next generation of the single-cycle opcode decoder. It accepts one instruction opcode at a time over a valid/ready handshake and steps an FSM through execute, memory and write-back phases. It drives the same datapath controls (WE, demux_sel, W, R, alucode) as the single-cycle decoder, adds a load instruction with a memory acknowledge, and adds a memory-timeout fault.

## Interface
- OPW, 4, opcode width (≥4)
- ALUW, 4, alucode width (≥4; codes zero-extended)
- TIMEOUT, 16, max cycles waiting for mem_ack before fault (≥1)

- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- instr_valid  in  1  opcode presented
- opcode  in  OPW  instruction opcode
- instr_ready  out  1  controller can accept an opcode
- mem_ack  in  1  memory completed current W/R access
- WE  out  1  register-file write enable
- demux_sel  out  1  1 = memory path selected
- W  out  1  memory write request
- R  out  1  memory read request
- alucode  out  ALUW  ALU operation
- busy  out  1  instruction in flight
- illegal  out  1  one-cycle pulse: undefined opcode rejected
- fault  out  1  sticky memory timeout

## Operation
- States: IDLE, EXEC, MEM, WB, FAULT. Outputs are Moore-decoded from the state register, the latched opcode register op_q and the illegal flag.
- IDLE: instr_ready=1. On instr_valid=1, opcode is latched into op_q. Next state:
  - 1..6 → EXEC
  - 7 (SW) → MEM
  - 8 (LW) → MEM
  - 0 (NOP) → IDLE
  - any other value → IDLE, with illegal registered to 1 for the following cycle.
- Opcodes are compared at the full OPW width.
- EXEC (1 cycle): WE=1, demux_sel=0. alucode per opcode: 1→0000, 2→0001, 3→0010, 4→0110, 5→0111, 6→1100. Next state is IDLE.
- MEM, SW: W=1, demux_sel=1, R=0, WE=0. Held until mem_ack=1 is sampled, then IDLE.
- MEM, LW: R=1, demux_sel=0, W=0, WE=0. Held until mem_ack=1 is sampled, then WB.
- WB (1 cycle): WE=1, demux_sel=1, alucode=0. Next state is IDLE.
- Timeout counter:
  - width clog2(TIMEOUT+1); cleared on entry to MEM; increments each MEM cycle without mem_ack.
  - When the count reaches TIMEOUT without an ack, next state is FAULT.
  - mem_ack sampled on the same edge as the limit wins (normal completion).
- FAULT: all datapath outputs 0, instr_ready=0, busy=0, fault=1. Exited only by reset.
- mem_ack outside MEM is ignored. instr_valid outside IDLE is ignored, and the opcode is not consumed.
- busy=1 in EXEC, MEM and WB; 0 otherwise.
- alucode is 0 in every state except EXEC.

## Timing
- Reset: rst_n sampled low at an edge gives the following values after that edge:
  - state=IDLE, op_q=0, counter=0, fault=0, illegal=0
  - WE=demux_sel=W=R=0, alucode=0, busy=0, instr_ready=1
- Reset mid-operation (any state, including FAULT) aborts immediately. No further W/R/WE pulses after the reset edge.
- ALU op: accepted at edge k. WE=1 for exactly cycle k..k+1. instr_ready returns at k+1. Throughput is 1 instruction per 2 cycles.
- SW with ack first MEM cycle: W high 1 cycle; 2 cycles total. With ack after n waits: W high n+1 cycles.
- LW with immediate ack: R for 1 cycle, then WE+demux_sel for 1 cycle; 3 cycles total.
- Timeout: W/R held TIMEOUT cycles, then fault=1 from the next cycle onward.
- illegal: high exactly one cycle, the cycle after acceptance. instr_ready stays 1 during it, so back-to-back acceptance is allowed.

## Test plan
- Reset then idle: rst_n=0 for 2 edges → all outputs 0 except instr_ready=1. Hold instr_valid=0 → no state change.
- ALU sweep: opcodes 1..6 back-to-back → WE=1 one cycle each, with alucode 0000, 0001, 0010, 0110, 0111, 1100; instr_ready toggles 1/0.
- SW with mem_ack delayed 3 cycles → W=demux_sel=1 for 4 cycles, WE never 1, then IDLE.
- LW with immediate ack → R=1 for 1 cycle, then WE=1 and demux_sel=1 for 1 cycle, 3 cycles total. A spurious mem_ack while in IDLE has no effect.
- Timeout with TIMEOUT=4, SW, mem_ack never asserted → W high 4 cycles, then fault=1 and instr_ready=0 persist. rst_n low → recovery to IDLE.
- Illegal and NOP: opcode 9 → illegal pulse of 1 cycle, no datapath outputs. Opcode 0 → nothing asserted. Reset asserted mid-LW while in WB → WE drops at the next edge.
